board_input_ctrl: RTL and testbench
===================================

BOARD_INPUT_CTRL -- requirements
Module: board_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable cycles (1 ms at 50 MHz) required before a debounced input updates.
REQ-002 clk  in  1  single system clock, 50 MHz.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 key_in  in  3  raw KEY[3:1], active-low pushbuttons, asynchronous to clk.
REQ-005 sw_in  in  10  raw SW[9:0] slide switches, asynchronous to clk.
REQ-006 avs_address  in  2  word address of the register slave.
REQ-007 avs_read / avs_write  in  1 each  read and write strobes, one cycle each, never both high together.
REQ-008 avs_writedata  in  32  write data; avs_readdata  out  32  read data.
REQ-009 avs_readdatavalid  out  1  high for exactly one cycle, one cycle after avs_read.
REQ-010 ledr_out  out  10  LEDR[9:0] drive; irq  out  1  level interrupt to the core.

Function
REQ-011 Each of the 13 inputs (bit order {key_in[2:0], sw_in[9:0]} = bits 12..0) SHALL pass a 2-flop synchronizer before any other logic.
REQ-012 Per input, a counter SHALL increment while the synchronized value differs from the debounced value and SHALL clear to 0 when they match.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value SHALL take the synchronized value on the next edge and the counter SHALL clear; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced value.
REQ-014 Counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap.
REQ-015 Event: a debounced KEY bit going 1->0 (press) or any debounced SW bit change SHALL set the matching PENDING bit in the same cycle the debounced value updates; a KEY release SHALL NOT set PENDING.
REQ-016 Register map: addr 0 STATUS (RO, [12:0] debounced levels); addr 1 IRQ_EN (RW, [12:0]); addr 2 PENDING (W1C, [12:0]); addr 3 LED (RW, [9:0] drives ledr_out).
REQ-017 Unused read bits SHALL return 0; writes to STATUS SHALL be ignored.
REQ-018 Read latency SHALL be fixed at 1 cycle; avs_readdata SHALL be registered and hold its value until the next read.
REQ-019 A write SHALL take effect on the clock edge where avs_write is high; a read issued the following cycle SHALL return the new value.
REQ-020 PENDING W1C and a new event on the same bit in the same cycle: the set SHALL win.
REQ-021 irq SHALL be a registered OR of (PENDING & IRQ_EN), asserted 1 cycle after the term becomes non-zero and deasserted 1 cycle after it clears.
REQ-022 The module SHALL not stall the bus: no waitrequest, and every access completes.

Reset
REQ-023 On rst_n low, all state SHALL clear asynchronously: IRQ_EN=0, PENDING=0, LED=0, counters=0, irq=0, avs_readdata=0, avs_readdatavalid=0.
REQ-024 Synchronizer and debounced flops for KEY bits SHALL reset to 1 (released) and for SW bits to 0, so that deassertion with idle inputs produces no event.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release, debouncing SHALL restart from 0.

Structure
REQ-026 Package board_io_pkg SHALL hold N_INPUTS=13, N_KEYS=3, N_SW=10, the register address constants, and the input reset-value vector.
REQ-027 One sub-module input_debounce (synchronizer, counter, debounced flop, 1-cycle rise/fall pulse outputs, parameterized reset value) SHALL be instantiated 13 times.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset with KEY=3'b111, SW=0 -> STATUS=0x1C00, PENDING=0, irq=0, ledr_out=0, no event after release.
REQ-029 sw_in[0] 0->1 held 10 cycles -> STATUS bit0=1 exactly 2 sync + 4 debounce cycles later; PENDING=0x001; with IRQ_EN=0x001 irq=1 one cycle later.
REQ-030 key_in[0] low for 3 cycles then high -> STATUS and PENDING unchanged, irq stays 0.
REQ-031 key_in[1] press (held low) then release, IRQ_EN=0x1FFF -> PENDING=0x0800 after press only; write 0x0800 to addr 2 -> PENDING=0, irq=0 one cycle later.
REQ-032 W1C to bit 3 on the same cycle sw_in[3] debounces to a new value -> PENDING bit3 remains 1.
REQ-033 Write 0x2AA to addr 3, read addr 3 -> ledr_out=0x2AA, avs_readdatavalid one cycle after avs_read, avs_readdata=0x000002AA.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants for the board input controller: input counts, register
// addresses and the idle (reset) level of every raw input.
package board_io_pkg;

   localparam int N_INPUTS = 13;
   localparam int N_KEYS   = 3;
   localparam int N_SW     = 10;

   localparam logic [1:0] ADDR_STATUS  = 2'd0;
   localparam logic [1:0] ADDR_IRQ_EN  = 2'd1;
   localparam logic [1:0] ADDR_PENDING = 2'd2;
   localparam logic [1:0] ADDR_LED     = 2'd3;

   // Keys are active-low (idle high), switches idle low; bit order {key, sw}.
   localparam logic [N_INPUTS-1:0] INPUT_RST_VAL = {{N_KEYS{1'b1}}, {N_SW{1'b0}}};
   localparam logic [N_INPUTS-1:0] SW_MASK       = {{N_KEYS{1'b0}}, {N_SW{1'b1}}};

   function automatic logic [31:0] zext_inputs(input logic [N_INPUTS-1:0] v);
      return {{(32 - N_INPUTS){1'b0}}, v};
   endfunction

endpackage

// File: rtl/board_input_ctrl_if.sv
// Register-slave bus between the processor and the board input controller.
interface board_input_ctrl_if;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, avs_readdatavalid
   );
endinterface

// File: rtl/input_debounce.sv
// One raw input: 2-flop synchronizer, stability counter and debounced level,
// with single-cycle rise/fall pulses asserted in the cycle before the level flips.
module input_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RST_VAL         = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             differ;
   logic             update;

   assign differ = (sync2_reg != level_reg);
   assign update = differ && (cnt_reg == CNT_MAX);

   // The update branch takes priority at CNT_MAX, so the counter never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= RST_VAL;
         sync2_reg <= RST_VAL;
         level_reg <= RST_VAL;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         if (update) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
         end else if (differ) begin
            cnt_reg <= cnt_reg + 1'b1;
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign level = level_reg;
   assign rise  = update &  sync2_reg;
   assign fall  = update & ~sync2_reg;

endmodule

// File: rtl/board_input_ctrl.sv
// Debounced KEY/SW inputs with event latching, interrupt generation and an
// LED output register, all behind a 4-word zero-wait register slave.
module board_input_ctrl
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_KEYS-1:0]   key_in,
   input  logic [N_SW-1:0]     sw_in,
   board_input_ctrl_if.slave   bus,
   output logic [N_SW-1:0]     ledr_out,
   output logic                irq
);
   logic [N_INPUTS-1:0] raw_vec;
   logic [N_INPUTS-1:0] level_vec;
   logic [N_INPUTS-1:0] rise_vec;
   logic [N_INPUTS-1:0] fall_vec;
   logic [N_INPUTS-1:0] event_vec;

   logic [N_INPUTS-1:0] irq_en_reg,  irq_en_next;
   logic [N_INPUTS-1:0] pending_reg, pending_next;
   logic [N_SW-1:0]     led_reg,     led_next;
   logic [31:0]         rdata_reg,   rdata_next;
   logic                rdvalid_reg;
   logic                irq_reg;
   logic [N_INPUTS-1:0] w1c_mask;
   logic                unused_wdata_bits;

   assign raw_vec = {key_in, sw_in};

   generate
      for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_deb
         input_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (INPUT_RST_VAL[gi])
         ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[gi]),
            .level (level_vec[gi]),
            .rise  (rise_vec[gi]),
            .fall  (fall_vec[gi])
         );
      end
   endgenerate

   // Keys are active-low: only a debounced fall is a press. Switches flag both edges.
   assign event_vec = fall_vec | (rise_vec & SW_MASK);

   assign unused_wdata_bits = ^bus.avs_writedata[31:N_INPUTS];

   always_comb begin
      irq_en_next = irq_en_reg;
      led_next    = led_reg;
      w1c_mask    = '0;
      rdata_next  = '0;
      if (bus.avs_write) begin
         case (bus.avs_address)
            ADDR_IRQ_EN:  irq_en_next = bus.avs_writedata[N_INPUTS-1:0];
            ADDR_PENDING: w1c_mask    = bus.avs_writedata[N_INPUTS-1:0];
            ADDR_LED:     led_next    = bus.avs_writedata[N_SW-1:0];
            default:      ;
         endcase
      end
      // A new event on the same bit as a W1C wins: set is applied after clear.
      pending_next = (pending_reg & ~w1c_mask) | event_vec;
      case (bus.avs_address)
         ADDR_STATUS:  rdata_next = zext_inputs(level_vec);
         ADDR_IRQ_EN:  rdata_next = zext_inputs(irq_en_reg);
         ADDR_PENDING: rdata_next = zext_inputs(pending_reg);
         default:      rdata_next = {{(32 - N_SW){1'b0}}, led_reg};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_reg  <= '0;
         pending_reg <= '0;
         led_reg     <= '0;
         rdata_reg   <= '0;
         rdvalid_reg <= 1'b0;
         irq_reg     <= 1'b0;
      end else begin
         irq_en_reg  <= irq_en_next;
         pending_reg <= pending_next;
         led_reg     <= led_next;
         rdvalid_reg <= bus.avs_read;
         irq_reg     <= |(pending_reg & irq_en_reg);
         if (bus.avs_read) begin
            rdata_reg <= rdata_next;
         end
      end
   end

   assign bus.avs_readdata      = rdata_reg;
   assign bus.avs_readdatavalid = rdvalid_reg;
   assign ledr_out              = led_reg;
   assign irq                   = irq_reg;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Bench for board_input_ctrl with DEBOUNCE_CYCLES=4: register table, directed
// debounce/event sequences, then random inputs and bus traffic against a window model.
module tb_board_input_ctrl;
   import board_io_pkg::*;

   localparam int DEB = 4;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic [2:0] key_in = 3'b111;
   logic [9:0] sw_in  = 10'd0;
   logic [9:0] ledr_out;
   logic       irq;

   board_input_ctrl_if bus_if ();

   board_input_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key_in),
      .sw_in    (sw_in),
      .bus      (bus_if),
      .ledr_out (ledr_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: an input flips its debounced level once its last DEB
   // synchronized samples (raw delayed two edges) all disagree with that level.
   typedef struct packed {
      logic [12:0]          deb;
      logic [12:0]          pend;
      logic [12:0]          en;
      logic [9:0]           led;
      logic                 irq;
      logic                 rdv;
      logic [31:0]          rd;
      logic [DEB:0][12:0]   hist;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r = '0;
      r.deb = INPUT_RST_VAL;
      for (int k = 0; k <= DEB; k++) r.hist[k] = INPUT_RST_VAL;
      return r;
   endfunction

   function automatic model_t model_step(input model_t c, input logic rd, input logic wr,
                                         input logic [1:0] a, input logic [31:0] wd,
                                         input logic [12:0] raw);
      model_t n;
      logic [12:0] nd;
      logic [12:0] ev;
      logic [12:0] w1c;
      logic        stable;
      n = c;
      n.rdv = rd;
      if (rd) begin
         case (a)
            2'd0:    n.rd = {19'd0, c.deb};
            2'd1:    n.rd = {19'd0, c.en};
            2'd2:    n.rd = {19'd0, c.pend};
            default: n.rd = {22'd0, c.led};
         endcase
      end
      n.irq = |(c.pend & c.en);
      nd = c.deb;
      for (int b = 0; b < 13; b++) begin
         stable = 1'b1;
         for (int k = 1; k <= DEB; k++)
            if (c.hist[k][b] == c.deb[b]) stable = 1'b0;
         if (stable) nd[b] = ~c.deb[b];
      end
      for (int b = 0; b < 13; b++)
         ev[b] = (b >= 10) ? (c.deb[b] & ~nd[b]) : (c.deb[b] ^ nd[b]);
      w1c = (wr && a == 2'd2) ? wd[12:0] : 13'd0;
      n.pend = (c.pend & ~w1c) | ev;
      if (wr && a == 2'd1) n.en  = wd[12:0];
      if (wr && a == 2'd3) n.led = wd[9:0];
      n.deb = nd;
      for (int k = DEB; k >= 1; k--) n.hist[k] = c.hist[k-1];
      n.hist[0] = raw;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, bus_if.avs_read, bus_if.avs_write, bus_if.avs_address,
                                  bus_if.avs_writedata, {key_in, sw_in});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle and compare every observable output against the model.
   task automatic tick();
      @(negedge clk);
      check("irq_model", {31'd0, irq}, {31'd0, m.irq});
      check("ledr_model", {22'd0, ledr_out}, {22'd0, m.led});
      check("rdvalid_model", {31'd0, bus_if.avs_readdatavalid}, {31'd0, m.rdv});
      check("rdata_model", bus_if.avs_readdata, m.rd);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.avs_address   = a;
      bus_if.avs_writedata = d;
      bus_if.avs_write     = 1'b1;
      tick();
      bus_if.avs_write     = 1'b0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.avs_address = a;
      bus_if.avs_read    = 1'b1;
      tick();
      bus_if.avs_read    = 1'b0;
      check("rdvalid_after_read", {31'd0, bus_if.avs_readdatavalid}, 32'd1);
      d = bus_if.avs_readdata;
      $display("read  addr=%0d data=%h", a, d);
   endtask

   task automatic read_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(name, d, exp);
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [9:0]  exp_led;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] d;
      bus_if.avs_address   = 2'd0;
      bus_if.avs_read      = 1'b0;
      bus_if.avs_write     = 1'b0;
      bus_if.avs_writedata = 32'd0;

      // Reset with idle inputs, then release: no event may follow.
      repeat (3) tick();
      rst_n = 1'b1;
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_ledr", {22'd0, ledr_out}, 32'd0);
      check("reset_rdvalid", {31'd0, bus_if.avs_readdatavalid}, 32'd0);
      repeat (8) tick();
      check("post_reset_irq", {31'd0, irq}, 32'd0);

      tbl = '{
         '{1'b0, 2'd0, 32'h0,         32'h0000_1C00, 10'h000},
         '{1'b0, 2'd2, 32'h0,         32'h0000_0000, 10'h000},
         '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0,         10'h000},
         '{1'b0, 2'd1, 32'h0,         32'h0000_1FFF, 10'h000},
         '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0,         10'h000},
         '{1'b0, 2'd0, 32'h0,         32'h0000_1C00, 10'h000},
         '{1'b1, 2'd3, 32'h0000_02AA, 32'h0,         10'h2AA},
         '{1'b0, 2'd3, 32'h0,         32'h0000_02AA, 10'h2AA},
         '{1'b1, 2'd3, 32'hFFFF_FD55, 32'h0,         10'h155},
         '{1'b0, 2'd3, 32'h0,         32'h0000_0155, 10'h155},
         '{1'b1, 2'd1, 32'h0,         32'h0,         10'h155},
         '{1'b0, 2'd1, 32'h0,         32'h0000_0000, 10'h155},
         '{1'b1, 2'd2, 32'h0000_1FFF, 32'h0,         10'h155},
         '{1'b0, 2'd2, 32'h0,         32'h0000_0000, 10'h155}
      };
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) begin
            bus_write(tbl[i].addr, tbl[i].wdata);
         end else begin
            bus_read(tbl[i].addr, d);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rd);
         end
         check($sformatf("tbl%0d_ledr", i), {22'd0, ledr_out}, {22'd0, tbl[i].exp_led});
      end

      // sw_in[0] rises: level flips on the 6th edge, irq one edge later.
      bus_write(2'd1, 32'h1);
      sw_in = 10'h001;
      repeat (5) tick();
      read_expect("sw0_before_deb", 2'd0, 32'h1C00);
      check("sw0_irq_not_yet", {31'd0, irq}, 32'd0);
      read_expect("sw0_after_deb", 2'd0, 32'h1C01);
      check("sw0_irq", {31'd0, irq}, 32'd1);
      read_expect("sw0_pending", 2'd2, 32'h001);
      bus_write(2'd2, 32'h1);
      tick();
      check("sw0_irq_cleared", {31'd0, irq}, 32'd0);

      // 3-cycle key glitch must be ignored.
      bus_write(2'd1, 32'h1FFF);
      key_in = 3'b110;
      repeat (3) tick();
      key_in = 3'b111;
      repeat (10) begin
         tick();
         check("glitch_irq", {31'd0, irq}, 32'd0);
      end
      read_expect("glitch_status", 2'd0, 32'h1C01);
      read_expect("glitch_pending", 2'd2, 32'h0);

      // key_in[1] press then release: only the press latches PENDING.
      key_in = 3'b101;
      repeat (8) tick();
      read_expect("press_pending", 2'd2, 32'h800);
      check("press_irq", {31'd0, irq}, 32'd1);
      key_in = 3'b111;
      repeat (8) tick();
      read_expect("release_pending", 2'd2, 32'h800);
      read_expect("release_status", 2'd0, 32'h1C01);
      bus_write(2'd2, 32'h800);
      check("w1c_irq_lag", {31'd0, irq}, 32'd1);
      tick();
      check("w1c_irq_low", {31'd0, irq}, 32'd0);
      read_expect("w1c_pending", 2'd2, 32'h0);

      // W1C landing on the same edge as a new sw_in[3] event: set wins.
      sw_in = 10'h009;
      repeat (5) tick();
      bus_write(2'd2, 32'h8);
      read_expect("collide_pending", 2'd2, 32'h008);
      read_expect("collide_status", 2'd0, 32'h1C09);
      bus_write(2'd2, 32'h8);
      read_expect("collide_cleared", 2'd2, 32'h0);

      // Reset mid-debounce: debouncing restarts from scratch after release.
      sw_in = 10'h029;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_irq", {31'd0, irq}, 32'd0);
      check("midrst_ledr", {22'd0, ledr_out}, 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      read_expect("midrst_before", 2'd0, 32'h1C00);
      read_expect("midrst_after", 2'd0, 32'h1C29);
      read_expect("midrst_pending", 2'd2, 32'h029);
      read_expect("midrst_irq_en", 2'd1, 32'h0);
      bus_write(2'd2, 32'h1FFF);

      // Random inputs and bus traffic, checked every cycle against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         if ($urandom_range(0, 5) == 0) begin
            logic [12:0] raw;
            raw = {key_in, sw_in};
            raw[$urandom_range(0, 12)] ^= 1'b1;
            {key_in, sw_in} = raw;
         end
         r = $urandom_range(0, 9);
         bus_if.avs_address   = 2'($urandom_range(0, 3));
         bus_if.avs_writedata = $urandom;
         bus_if.avs_read      = (r < 3);
         bus_if.avs_write     = (r == 3);
         if (cyc == 1500) rst_n = 1'b0;
         if (cyc == 1501) rst_n = 1'b1;
         tick();
      end
      bus_if.avs_read  = 1'b0;
      bus_if.avs_write = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
